// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud parameters.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_D_WIDTH     = 8;
    localparam int unsigned UART_CLK_PER_BIT = 868;  // 100 MHz / 115200
    localparam int unsigned UART_CNT_WIDTH   = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1-style serial receiver: mid-bit sampling of a synchronised RX line, one-cycle
// rx_done on a good frame and frame_err when the stop bit reads low.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned D_WIDTH     = UART_D_WIDTH,
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int unsigned CNT_WIDTH   = UART_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_done,
    output logic               frame_err,
    output logic               busy
);

    localparam int unsigned IDX_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] HALF_M1  = CNT_WIDTH'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] BIT_M1   = CNT_WIDTH'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(D_WIDTH - 1);

    logic                 rx_s;
    uart_state_e          state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [D_WIDTH-1:0]   shreg;
    logic                 wait_high;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wait_high <= 1'b0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // After a framing error the line must go high before a new start counts.
                    if (wait_high) begin
                        if (rx_s) begin
                            wait_high <= 1'b0;
                        end
                    end else if (!rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            rx_data <= shreg;
                            rx_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
module tb_uart_rx_byte;

    localparam int CPB    = 16;
    localparam int HALF   = CPB / 2;
    // Cycle count from driving the start bit low to the negedge showing rx_done.
    localparam int LAT    = 1 + 2 + HALF + 8 * CPB + CPB;

    logic       clk;
    logic       n_rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int n_checks;
    int n_fail;
    int cyc;

    int         done_q[$];
    logic [7:0] data_q[$];
    int         err_cnt;
    int         busy_cnt;
    int         overlap_cnt;
    int         long_cnt;
    logic       prev_done;
    logic       prev_err;

    uart_rx_byte #(
        .D_WIDTH     (8),
        .CLK_PER_BIT (CPB),
        .CNT_WIDTH   (5)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        err_cnt     = 0;
        busy_cnt    = 0;
        overlap_cnt = 0;
        long_cnt    = 0;
        prev_done   = 1'b0;
        prev_err    = 1'b0;
    end

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_q.push_back(cyc);
            data_q.push_back(rx_data);
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (rx_done === 1'b1 && frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
        if ((rx_done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_err))
            long_cnt = long_cnt + 1;
        prev_done = (rx_done === 1'b1);
        prev_err  = (frame_err === 1'b1);
    end

    task automatic clear_mon();
        done_q.delete();
        data_q.delete();
        err_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Assumes the caller is aligned at posedge+1.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int start_cyc);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rx_data !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: data=%h done=%b err=%b busy=%b want 00 0 0 0",
                     rx_data, rx_done, frame_err, busy);
        end
        n_rst = 1'b1;
        idle(5);
        n_checks++;
        if (busy !== 1'b0 || rx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b want 0 0", busy, rx_done);
        end
    endtask

    task automatic test_single();
        int s;
        clear_mon();
        send_frame(8'h63, 1'b1, s);
        idle(20);
        n_checks++;
        if (done_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_done_count: got %0d want 1", done_q.size());
        end
        n_checks++;
        if (data_q.size() < 1 || data_q[0] !== 8'h63) begin
            n_fail++;
            $display("FAIL single_data: got %h want 63", rx_data);
        end
        n_checks++;
        if (err_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err_busy: err=%0d busy=%b want 0 0", err_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int s1;
        clear_mon();
        send_frame(8'h35, 1'b1, s0);
        send_frame(8'h20, 1'b1, s1);
        idle(20);
        n_checks++;
        if (done_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", done_q.size());
        end else begin
            n_checks++;
            if (data_q[0] !== 8'h35 || data_q[1] !== 8'h20) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h want 35 20", data_q[0], data_q[1]);
            end
            n_checks++;
            if (done_q[1] - done_q[0] != 10 * CPB) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d want %0d", done_q[1] - done_q[0], 10 * CPB);
            end
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_err: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        n_checks++;
        if (done_q.size() != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL glitch_outputs: done=%0d err=%0d want 0 0", done_q.size(), err_cnt);
        end
        n_checks++;
        if (busy_cnt < 1 || busy_cnt > HALF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: busy_cycles=%0d busy=%b want 1..%0d and 0",
                     busy_cnt, busy, HALF);
        end
    endtask

    task automatic test_frame_err();
        int s;
        clear_mon();
        send_frame(8'h36, 1'b0, s);
        idle(30);
        n_checks++;
        if (err_cnt != 1 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL ferr_pulses: err=%0d done=%0d want 1 0", err_cnt, done_q.size());
        end
        n_checks++;
        if (rx_data !== 8'h20) begin
            n_fail++;
            $display("FAIL ferr_data_held: got %h want 20", rx_data);
        end
    endtask

    task automatic test_reset_midframe();
        int s;
        logic [7:0] a5;
        a5 = 8'hA5;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(a5[i]);
        rx = a5[4];
        repeat (HALF) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (rx_data !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_vals: data=%h done=%b err=%b busy=%b want 00 0 0 0",
                     rx_data, rx_done, frame_err, busy);
        end
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(5);
        n_checks++;
        if (done_q.size() != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL midrst_aborted: done=%0d err=%0d want 0 0", done_q.size(), err_cnt);
        end
        send_frame(8'h5A, 1'b1, s);
        idle(20);
        n_checks++;
        if (done_q.size() != 1 || data_q[0] !== 8'h5A || err_cnt != 0) begin
            n_fail++;
            $display("FAIL midrst_next: done=%0d data=%h err=%0d want 1 5a 0",
                     done_q.size(), rx_data, err_cnt);
        end
    endtask

    task automatic test_extremes();
        int s;
        logic [7:0] vals[2];
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_frame(vals[k], 1'b1, s);
            idle(20);
            n_checks++;
            if (done_q.size() != 1) begin
                n_fail++;
                $display("FAIL extreme_count[%0d]: got %0d want 1", k, done_q.size());
            end else begin
                n_checks++;
                if (data_q[0] !== vals[k]) begin
                    n_fail++;
                    $display("FAIL extreme_data[%0d]: got %h want %h", k, data_q[0], vals[k]);
                end
                n_checks++;
                if (done_q[0] != s + LAT) begin
                    n_fail++;
                    $display("FAIL extreme_timing[%0d]: got cycle %0d want %0d",
                             k, done_q[0], s + LAT);
                end
            end
        end
        n_checks++;
        if (overlap_cnt != 0 || long_cnt != 0) begin
            n_fail++;
            $display("FAIL pulse_shape: overlap=%0d long=%0d want 0 0", overlap_cnt, long_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        rx       = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded 1 ms");
        $fatal(1, "timeout");
    end

endmodule
